// File: rtl/ro_meter_pkg.sv
// Shared types and constants for the ring-oscillator
// configuration loader and frequency meter.
package ro_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_MEASURE,
    ST_DONE
  } state_t;

  localparam int HOLD_CYCLES = 4;

  typedef enum logic [2:0] {
    SRC_DIV_CLK = 3'd0,
    SRC_XOR3    = 3'd1,
    SRC_XOR5    = 3'd2,
    SRC_XOR1    = 3'd3,
    SRC_XOR2    = 3'd4,
    SRC_NAND5   = 3'd5,
    SRC_NOR5    = 3'd6,
    SRC_ADD5    = 3'd7
  } clk_src_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer; with EDGE set, q is a one-cycle
// rising-edge pulse, otherwise q is the synchronized level.
module sync_edge_detect #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  if (EDGE) begin : g_edge
    logic s3_q;
    always_ff @(posedge clk) begin
      if (!rst_n) s3_q <= 1'b0;
      else        s3_q <= s2_q;
    end
    assign q = s2_q & ~s3_q;
  end else begin : g_level
    assign q = s2_q;
  end

endmodule

// File: rtl/ro_cfg_loader_meter.sv
// Shifts a config word into an RO tile, releases its reset for a
// gate window and counts synchronized tap rising edges.
module ro_cfg_loader_meter
  import ro_meter_pkg::*;
#(
  parameter int CFG_W  = 12,
  parameter int DIV    = 4,
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg_word,
  input  logic [2:0]        clk_src,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  freq_count,
  output logic              echo_ok,
  output logic              shift_clk,
  output logic              shift_dta,
  output logic [2:0]        clk_source,
  output logic              dut_rst,
  input  logic              dut_tap,
  input  logic              dut_echo
);

  localparam int PH_W = $clog2(2 * DIV);
  localparam int BW   = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam int HC_W = $clog2(HOLD_CYCLES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0] PH_HI   = PH_W'(DIV);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

  logic tap_rise;
  logic echo_s;

  sync_edge_detect #(.EDGE(1'b1)) u_tap (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_tap),
    .q     (tap_rise)
  );

  sync_edge_detect #(.EDGE(1'b0)) u_echo (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_echo),
    .q     (echo_s)
  );

  state_t              state_q, state_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [GATE_W-1:0]   gc_q, gc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [HC_W-1:0]     hc_q, hc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    freq_q, freq_d;
  logic                echo_ok_q, echo_ok_d;
  logic                sclk_q, sclk_d;
  logic                sdta_q, sdta_d;
  logic [2:0]          src_q, src_d;
  logic                drst_q, drst_d;

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    gate_d    = gate_q;
    gc_d      = gc_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    hc_d      = hc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    freq_d    = freq_q;
    echo_ok_d = echo_ok_q;
    sclk_d    = sclk_q;
    sdta_d    = sdta_q;
    src_d     = src_q;
    drst_d    = drst_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cfg_d   = cfg_word;
          gate_d  = gate_cycles;
          src_d   = clk_src;
          cnt_d   = '0;
          ph_d    = '0;
          bit_d   = BW'(CFG_W - 1);
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          sdta_d  = cfg_word[CFG_W-1];
          drst_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d   = '0;
          sclk_d = 1'b0;
          if (bit_q == '0) begin
            state_d = ST_HOLD;
            hc_d    = '0;
          end else begin
            bit_d  = bit_q - BW'(1);
            sdta_d = cfg_q[bit_q - BW'(1)];
          end
        end else begin
          ph_d   = ph_q + PH_W'(1);
          sclk_d = (ph_q + PH_W'(1)) >= PH_HI;
        end
      end
      ST_HOLD: begin
        hc_d = hc_q + HC_W'(1);
        if (hc_q == HC_LAST) begin
          echo_ok_d = (echo_s == cfg_q[CFG_W-1]);
          gc_d      = '0;
          if (gate_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            freq_d  = cnt_q;
          end else begin
            state_d = ST_MEASURE;
            drst_d  = 1'b0;
          end
        end
      end
      ST_MEASURE: begin
        if (tap_rise && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        gc_d = gc_q + GATE_W'(1);
        if (gc_q == gate_q - GATE_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          drst_d  = 1'b1;
          freq_d  = cnt_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '0;
      gate_q    <= '0;
      gc_q      <= '0;
      cnt_q     <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      hc_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      freq_q    <= '0;
      echo_ok_q <= 1'b0;
      sclk_q    <= 1'b0;
      sdta_q    <= 1'b0;
      src_q     <= '0;
      drst_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      gate_q    <= gate_d;
      gc_q      <= gc_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      hc_q      <= hc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      freq_q    <= freq_d;
      echo_ok_q <= echo_ok_d;
      sclk_q    <= sclk_d;
      sdta_q    <= sdta_d;
      src_q     <= src_d;
      drst_q    <= drst_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign freq_count = freq_q;
  assign echo_ok    = echo_ok_q;
  assign shift_clk  = sclk_q;
  assign shift_dta  = sdta_q;
  assign clk_source = src_q;
  assign dut_rst    = drst_q;

endmodule

// File: tb/tb_ro_cfg_loader_meter.sv
// Directed bench for ro_cfg_loader_meter: vector table plus
// saturation, reset-abort and start-during-DONE sequences.
module tb_ro_cfg_loader_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] cfg_word = '0;
  logic [2:0]  clk_src = '0;
  logic [15:0] gate_cycles = '0;
  logic        busy, done, echo_ok;
  logic [15:0] freq_count;
  logic        shift_clk, shift_dta, dut_rst;
  logic [2:0]  clk_source;
  logic        dut_tap = 1'b0;
  logic        dut_echo;

  logic        s_start = 1'b0;
  logic [11:0] s_cfg = 12'h800;
  logic [2:0]  s_src = 3'd2;
  logic [15:0] s_gate = 16'd100;
  logic        s_busy, s_done, s_echo_ok;
  logic [3:0]  s_freq;
  logic        s_sclk, s_sdta, s_rst;
  logic [2:0]  s_src_o;
  logic        s_echo = 1'b0;

  int total = 0;
  int bad = 0;
  int tap_per = 0;
  int tph = 0;
  bit bad_echo = 1'b0;
  logic [11:0] chain = '0;

  always #5 clk = ~clk;

  ro_cfg_loader_meter u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_word(cfg_word), .clk_src(clk_src),
    .gate_cycles(gate_cycles), .busy(busy), .done(done),
    .freq_count(freq_count), .echo_ok(echo_ok),
    .shift_clk(shift_clk), .shift_dta(shift_dta),
    .clk_source(clk_source), .dut_rst(dut_rst),
    .dut_tap(dut_tap), .dut_echo(dut_echo)
  );

  ro_cfg_loader_meter #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .cfg_word(s_cfg), .clk_src(s_src),
    .gate_cycles(s_gate), .busy(s_busy), .done(s_done),
    .freq_count(s_freq), .echo_ok(s_echo_ok),
    .shift_clk(s_sclk), .shift_dta(s_sdta),
    .clk_source(s_src_o), .dut_rst(s_rst),
    .dut_tap(dut_tap), .dut_echo(s_echo)
  );

  // behavioral tile chain: first bit shifted ends at the tail
  always @(posedge shift_clk) chain <= {chain[10:0], shift_dta};
  assign dut_echo = bad_echo ? 1'b0 : chain[11];

  initial begin
    forever begin
      @(negedge clk);
      if (tap_per == 0) begin
        dut_tap = 1'b0;
        tph = 0;
      end else begin
        tph = (tph + 1) % tap_per;
        dut_tap = (tph < tap_per / 2);
      end
    end
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act,
                         input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d",
               nm, act, lo, hi);
    end
  endtask

  typedef struct {
    logic [11:0] cfg;
    logic [2:0]  src;
    int          gate;
    int          per;
    bit          bad;
    int          lo;
    int          hi;
    bit          echo;
    bit          mid_start;
    bit          coinc;
  } vec_t;

  vec_t vt[6];

  task automatic run_op(input vec_t v, input int idx);
    int n;
    int r;
    int low;
    bit prev;
    bit rt_ok;
    bit src_ok;
    @(negedge clk);
    cfg_word = v.cfg;
    clk_src = v.src;
    gate_cycles = 16'(v.gate);
    tap_per = v.per;
    bad_echo = v.bad;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    r = 0;
    low = 0;
    prev = 1'b0;
    rt_ok = 1'b1;
    src_ok = 1'b1;
    chk($sformatf("v%0d busy_k1", idx), busy, 1);
    while (!done && n < v.gate + 300) begin
      if (shift_clk && !prev) begin
        if (n != 5 + 8 * r) rt_ok = 1'b0;
        r++;
      end
      prev = shift_clk;
      if (!dut_rst) low++;
      if (clk_source != v.src) src_ok = 1'b0;
      if (v.mid_start) begin
        if (n == 30) begin
          start = 1'b1;
          cfg_word = ~v.cfg;
          gate_cycles = 16'd7;
        end else if (n == 31) begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d done_lat", idx), n, 101 + v.gate);
    chk_rng($sformatf("v%0d freq", idx), freq_count, v.lo, v.hi);
    chk($sformatf("v%0d echo_ok", idx), echo_ok, v.echo);
    chk($sformatf("v%0d busy_done", idx), busy, 0);
    chk($sformatf("v%0d src_ok", idx), src_ok && clk_source == v.src, 1);
    chk($sformatf("v%0d sclk_rises", idx), r, 12);
    chk($sformatf("v%0d rise_time", idx), rt_ok, 1);
    chk($sformatf("v%0d rst_low", idx), low, v.gate);
    chk($sformatf("v%0d chain", idx), chain, v.cfg);
    if (v.coinc) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d start_at_done", idx), busy, 0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    vt[0] = '{12'hA5C, 3'd5, 1000, 10, 1'b0, 99, 101, 1'b1, 1'b0, 1'b0};
    vt[1] = '{12'hA5C, 3'd3, 0, 10, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1};
    vt[2] = '{12'hA5C, 3'd1, 20, 0, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{12'h3FF, 3'd0, 20, 0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{12'h800, 3'd7, 50, 4, 1'b0, 11, 14, 1'b1, 1'b1, 1'b0};
    vt[5] = '{12'h001, 3'd6, 100, 2, 1'b0, 48, 51, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_outs",
        {busy, done, freq_count, echo_ok, shift_clk, shift_dta,
         clk_source, dut_rst},
        {1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_op(vt[i], i);

    tap_per = 2;
    s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    n = 1;
    while (!s_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("sat_lat", n, 201);
    chk("sat_freq", s_freq, 15);

    @(negedge clk);
    cfg_word = 12'hA5C;
    clk_src = 3'd5;
    gate_cycles = 16'd50;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("abort_pre_sclk", shift_clk, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outs",
        {busy, done, freq_count, echo_ok, shift_clk, shift_dta,
         clk_source, dut_rst},
        {1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);
    run_op(vt[4], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
